image_port: RTL and testbench

- Image memory responder on the other end of the pixel-processing engine's row/col interface.
- Holds a 64x64 input image and a 64x64 output image (24-bit RGB: R 23:16, G 15:8, B 7:0).
- Loads the input image from a valid/ready stream, serves the engine's pixel reads, and captures its write-enabled output pixels.
- Streams the finished output image out on a valid/ready port.

---
 rtl/image_port.sv | 129 ++++++++++++
 tb/tb_image_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/image_port.sv
// Image memory responder for the pixel engine: loads an input image from a stream,
// serves combinational row/col reads, captures engine writes and streams the result out.
module image_port #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [PIX_W-1:0]  ld_pix,
  output logic              ld_ready,
  output logic              img_loaded,
  input  logic [ADDR_W-1:0] row,
  input  logic [ADDR_W-1:0] col,
  output logic [PIX_W-1:0]  in_pix,
  input  logic              out_we,
  input  logic [PIX_W-1:0]  out_pix,
  input  logic              dump_req,
  output logic              dp_valid,
  output logic [PIX_W-1:0]  dp_pix,
  output logic              dp_last,
  input  logic              dp_ready
);

  localparam int unsigned CNT_W = 2 * ADDR_W;
  localparam int unsigned DEPTH = 1 << CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, PROC, DUMP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] dp_cnt_q, dp_cnt_d;
  logic [CNT_W-1:0] dp_cnt_inc_c;
  logic             ld_ready_d, img_loaded_d;
  logic             dp_valid_d, dp_last_d;
  logic [PIX_W-1:0] dp_pix_d;
  logic             in_wr_c, out_wr_c;

  logic [PIX_W-1:0] in_mem  [DEPTH];
  logic [PIX_W-1:0] out_mem [DEPTH];

  assign dp_cnt_inc_c = dp_cnt_q + CNT_W'(1);

  // Engine reads are asynchronous so a row/col change is visible in the same cycle.
  assign in_pix = in_mem[{row, col}];

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    dp_cnt_d   = dp_cnt_q;
    dp_valid_d = dp_valid;
    dp_pix_d   = dp_pix;
    dp_last_d  = dp_last;
    in_wr_c    = 1'b0;
    out_wr_c   = 1'b0;

    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (ld_valid && ld_ready) begin
          in_wr_c  = 1'b1;
          ld_cnt_d = ld_cnt_q + CNT_W'(1);
          if (ld_cnt_q == CNT_MAX) state_d = PROC;
        end
      end
      PROC: begin
        out_wr_c = out_we;
        if (dump_req) begin
          state_d    = DUMP;
          dp_cnt_d   = '0;
          dp_valid_d = 1'b1;
          dp_pix_d   = out_mem[0];
          dp_last_d  = 1'b0;
        end
      end
      DUMP: begin
        if (dp_valid && dp_ready) begin
          if (dp_last) begin
            dp_valid_d = 1'b0;
            dp_last_d  = 1'b0;
            state_d    = IDLE;
          end else begin
            dp_cnt_d  = dp_cnt_inc_c;
            dp_pix_d  = out_mem[dp_cnt_inc_c];
            dp_last_d = (dp_cnt_inc_c == CNT_MAX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Level outputs follow the state being entered so they line up with it.
    ld_ready_d   = (state_d == LOAD);
    img_loaded_d = (state_d == PROC);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      dp_cnt_q   <= '0;
      ld_ready   <= 1'b0;
      img_loaded <= 1'b0;
      dp_valid   <= 1'b0;
      dp_pix     <= '0;
      dp_last    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      dp_cnt_q   <= dp_cnt_d;
      ld_ready   <= ld_ready_d;
      img_loaded <= img_loaded_d;
      dp_valid   <= dp_valid_d;
      dp_pix     <= dp_pix_d;
      dp_last    <= dp_last_d;
    end
  end

  // Image storage is not reset.
  always_ff @(posedge clk) begin
    if (in_wr_c)  in_mem[ld_cnt_q]     <= ld_pix;
    if (out_wr_c) out_mem[{row, col}] <= out_pix;
  end

endmodule

// File: tb/tb_image_port.sv
// Scoreboard bench for image_port: loads, engine writes, dumps with stalls and reset recovery.
module tb_image_port;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned PIX_W  = 24;
  localparam int          NPIX   = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_valid, ld_ready, img_loaded;
  logic [PIX_W-1:0]  ld_pix, in_pix, out_pix, dp_pix;
  logic [ADDR_W-1:0] row, col;
  logic              out_we, dump_req, dp_valid, dp_last, dp_ready;

  int errors = 0;
  int checks = 0;

  logic [PIX_W-1:0] out_model [NPIX];
  logic [PIX_W-1:0] exp_q [$];

  image_port #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_pix(ld_pix), .ld_ready(ld_ready), .img_loaded(img_loaded),
    .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .dump_req(dump_req), .dp_valid(dp_valid), .dp_pix(dp_pix), .dp_last(dp_last),
    .dp_ready(dp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream a full image; optional ld_valid toggling and out_we noise during LOAD.
  task automatic load_image(input bit toggle, input int offset, input bit we_noise);
    int n = 0;
    int cyc = 0;
    int hi = 0;
    bit drv, rdy;
    while (n < NPIX && cyc < 20000) begin
      drv = toggle ? (cyc % 2 == 0) : 1'b1;
      rdy = ld_ready;
      if (rdy) hi++;
      ld_valid = drv;
      ld_pix   = drv ? PIX_W'(n + offset) : 24'hDEAD00;
      if (we_noise) begin
        out_we  = 1'b1;
        out_pix = 24'hBADBAD;
        row     = n[11:6];
        col     = n[5:0];
      end
      if (n == NPIX - 1 && rdy) check("img_loaded_early", 32'(img_loaded), 32'd0);
      @(posedge clk); #1;
      if (drv && rdy) n++;
      cyc++;
    end
    ld_valid = 1'b0;
    out_we   = 1'b0;
    check("load_count", 32'(n), 32'(NPIX));
    if (!toggle) check("ld_ready_cycles", 32'(hi), 32'(NPIX));
    check("ld_ready_drop", 32'(ld_ready), 32'd0);
    check("img_loaded", 32'(img_loaded), 32'd1);
  endtask

  task automatic write_px(input int idx, input logic [PIX_W-1:0] v);
    row     = idx[11:6];
    col     = idx[5:0];
    out_pix = v;
    out_we  = 1'b1;
    @(posedge clk); #1;
    out_we  = 1'b0;
    out_model[idx] = v;
  endtask

  // Request a dump and check it against the model; optional 3-cycle stall or reset abort.
  task automatic run_dump(input int stall_at, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int stall = 0;
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(out_model[i]);
    dp_ready = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("dp_valid_rise", 32'(dp_valid), 32'd1);
    check("img_loaded_in_dump", 32'(img_loaded), 32'd0);
    while (idx < NPIX && cyc < 20000) begin
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_dp_valid", 32'(dp_valid), 32'd0);
        check("abort_img_loaded", 32'(img_loaded), 32'd0);
        check("abort_dp_last", 32'(dp_last), 32'd0);
        check("abort_dp_pix", 32'(dp_pix), 32'd0);
        check("abort_ld_ready", 32'(ld_ready), 32'd0);
        exp_q.delete();
        return;
      end
      check("dp_valid", 32'(dp_valid), 32'd1);
      check("dp_pix", 32'(dp_pix), 32'(exp_q[0]));
      check("dp_last", 32'(dp_last), 32'(idx == NPIX - 1));
      if (idx == 63) check("dump_px63", 32'(dp_pix), 32'h123456);
      if (idx == stall_at && stall < 3) begin
        dp_ready = 1'b0;
        stall++;
      end else begin
        dp_ready = 1'b1;
        void'(exp_q.pop_front());
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("dump_count", 32'(idx), 32'(NPIX));
    check("dump_end_valid", 32'(dp_valid), 32'd0);
    check("dump_end_last", 32'(dp_last), 32'd0);
    @(posedge clk); #1;
    check("dump_back_to_load", 32'(ld_ready), 32'd1);
  endtask

  initial begin
    ld_valid = 1'b0; ld_pix = '0; row = '0; col = '0;
    out_we = 1'b0; out_pix = '0; dump_req = 1'b0; dp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_img_loaded", 32'(img_loaded), 32'd0);
    check("rst_dp_valid", 32'(dp_valid), 32'd0);
    check("rst_dp_pix", 32'(dp_pix), 32'd0);
    check("rst_dp_last", 32'(dp_last), 32'd0);
    rst_n = 1'b1;

    load_image(1'b0, 0, 1'b0);
    row = 6'd5; col = 6'd7; #1;
    check("in_pix_5_7", 32'(in_pix), 32'h000147);
    row = 6'd63; col = 6'd63; #1;
    check("in_pix_63_63", 32'(in_pix), 32'h000FFF);

    for (int i = 0; i < NPIX; i++) write_px(i, PIX_W'((i * 37) ^ 32'h005A3C00));
    write_px(63, 24'hAA55CC);
    write_px(63, 24'h123456);

    run_dump(10, -1);

    load_image(1'b1, 0, 1'b1);
    for (int i = 0; i < NPIX; i++) begin
      row = i[11:6]; col = i[5:0]; #1;
      check("in_pix_all", 32'(in_pix), 32'(i));
    end

    run_dump(-1, 2000);

    @(posedge clk); #1;
    rst_n = 1'b1;
    dp_ready = 1'b0;
    @(posedge clk); #1;
    check("rec_ld_ready", 32'(ld_ready), 32'd1);
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    check("ign_dp_valid", 32'(dp_valid), 32'd0);
    check("ign_ld_ready", 32'(ld_ready), 32'd1);
    check("ign_img_loaded", 32'(img_loaded), 32'd0);
    @(posedge clk); #1;
    check("ign_dp_valid2", 32'(dp_valid), 32'd0);

    load_image(1'b0, 7, 1'b0);
    row = 6'd0; col = 6'd0; #1;
    check("rel_in_pix_0", 32'(in_pix), 32'h000007);
    row = 6'd63; col = 6'd63; #1;
    check("rel_in_pix_last", 32'(in_pix), 32'h001006);

    run_dump(-1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
